// File: rtl/vga_bounce_box_if.sv
// Pixel-stream bus between the VGA timing counters and the colour source.
// Inputs: pix_en (pixel strobe), de (display enable), px/py (active-area
// coordinates), frame_tick (once-per-frame pulse in vertical blanking).
// Outputs: vga_r/vga_g/vga_b (4-bit colour), de_out (de aligned with colour).
// master: timing side (drives strobes/coordinates, receives colour).
// slave : colour source (vga_bounce_box).
interface vga_bounce_box_if;
    logic       pix_en;
    logic       de;
    logic [9:0] px;
    logic [9:0] py;
    logic       frame_tick;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       de_out;

    modport master (
        output pix_en, de, px, py, frame_tick,
        input  vga_r, vga_g, vga_b, de_out
    );

    modport slave (
        input  pix_en, de, px, py, frame_tick,
        output vga_r, vga_g, vga_b, de_out
    );
endinterface

// File: rtl/vga_bounce_box.sv
// Bouncing-box pixel colour source, sits just upstream of the VGA sync stage.
// A solid BOX_SIZE square moves STEP pixels per frame on each axis, bounces off
// the screen edges and steps through a 7-entry palette on every bounce.
// Ports:
//   clk   - system clock (50 MHz)
//   rst_n - asynchronous active-low reset
//   bus   - vga_bounce_box_if.slave: pix_en/de/px/py/frame_tick in,
//           vga_r/vga_g/vga_b/de_out out (all outputs registered)
// Optional: define VGA_BORDER_EN to draw a white 1-pixel frame around the
// active area; the frame overrides the box.
module vga_bounce_box #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned BOX_SIZE  = 32,
    parameter int unsigned STEP      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    vga_bounce_box_if.slave bus
);

    localparam int unsigned CW = 10;   // coordinate width
    localparam int unsigned NW = 11;   // widened width for overflow-free sums
    localparam int unsigned IW = 3;    // colour index width
    localparam int unsigned SW = CW + 2;

    localparam logic [NW-1:0] BOX_W  = NW'(BOX_SIZE);
    localparam logic [NW-1:0] STEP_W = NW'(STEP);
    localparam logic [NW-1:0] X_MAX  = NW'(H_DISPLAY - BOX_SIZE);
    localparam logic [NW-1:0] Y_MAX  = NW'(V_DISPLAY - BOX_SIZE);

    logic [CW-1:0] box_x, box_y;
    logic          dir_x, dir_y;      // 0 = increasing, 1 = decreasing
    logic [IW-1:0] cidx;

    logic [SW-1:0] step_x, step_y;    // {bounce, next dir, next pos}
    logic [IW-1:0] cidx_next;

    logic [NW-1:0] px_w, py_w, bx_w, by_w;
    logic          in_box;
    logic          on_border;
    logic [11:0]   pix_rgb;
    logic [11:0]   rgb_q;
    logic          de_q;

    // One motion step on one axis; nx+BOX > LIMIT is evaluated as nx > LIMIT-BOX.
    function automatic logic [SW-1:0] axis_step(
        input logic [CW-1:0] pos,
        input logic          dir,
        input logic [NW-1:0] pos_max
    );
        logic [NW-1:0] nx;
        logic [CW-1:0] npos;
        logic          ndir;
        logic          bnc;
        nx   = {1'b0, pos} + STEP_W;
        npos = pos;
        ndir = dir;
        bnc  = 1'b0;
        if (!dir) begin
            if (nx > pos_max) begin
                npos = pos_max[CW-1:0];
                ndir = 1'b1;
                bnc  = 1'b1;
            end else begin
                npos = nx[CW-1:0];
            end
        end else if ({1'b0, pos} < STEP_W) begin
            npos = '0;
            ndir = 1'b0;
            bnc  = 1'b1;
        end else begin
            npos = pos - STEP_W[CW-1:0];
        end
        return {bnc, ndir, npos};
    endfunction

    // Next box state; simultaneous X/Y bounces advance the colour only once.
    always_comb begin
        step_x    = axis_step(box_x, dir_x, X_MAX);
        step_y    = axis_step(box_y, dir_y, Y_MAX);
        cidx_next = cidx;
        if (step_x[SW-1] || step_y[SW-1]) begin
            cidx_next = (cidx == IW'(7)) ? IW'(1) : cidx + IW'(1);
        end
    end

    // Box state, updated once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x <= '0;
            box_y <= '0;
            dir_x <= 1'b0;
            dir_y <= 1'b0;
            cidx  <= IW'(2);
        end else if (bus.frame_tick) begin
            box_x <= step_x[CW-1:0];
            box_y <= step_y[CW-1:0];
            dir_x <= step_x[CW];
            dir_y <= step_y[CW];
            cidx  <= cidx_next;
        end
    end

`ifdef VGA_BORDER_EN
    localparam logic [CW-1:0] H_LAST = CW'(H_DISPLAY - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_DISPLAY - 1);
    assign on_border = (bus.px == '0) || (bus.px == H_LAST) ||
                       (bus.py == '0) || (bus.py == V_LAST);
`else
    assign on_border = 1'b0;
`endif

    // Pixel colour from the pre-update box state.
    always_comb begin
        px_w    = {1'b0, bus.px};
        py_w    = {1'b0, bus.py};
        bx_w    = {1'b0, box_x};
        by_w    = {1'b0, box_y};
        in_box  = (px_w >= bx_w) && (px_w < bx_w + BOX_W) &&
                  (py_w >= by_w) && (py_w < by_w + BOX_W);
        pix_rgb = '0;
        if (bus.de) begin
            if (on_border) begin
                pix_rgb = 12'hFFF;
            end else if (in_box) begin
                pix_rgb = {{4{cidx[2]}}, {4{cidx[1]}}, {4{cidx[0]}}};
            end
        end
    end

    // Output registers advance only on pixel strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
        end else if (bus.pix_en) begin
            rgb_q <= pix_rgb;
            de_q  <= bus.de;
        end
    end

    assign bus.vga_r  = rgb_q[11:8];
    assign bus.vga_g  = rgb_q[7:4];
    assign bus.vga_b  = rgb_q[3:0];
    assign bus.de_out = de_q;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Self-checking bench for vga_bounce_box: reset values, pixel vector table,
// strobe hold, motion/bounce/colour sequences, mid-frame reset, and a square
// (640x640) instance where both axes bounce on the same tick.
module tb_vga_bounce_box;

    localparam int unsigned H = 640;
    localparam int unsigned V = 480;
    localparam int unsigned B = 32;
    localparam int unsigned S = 4;

    // Packed result: {r, g, b, de_out}
    localparam logic [12:0] OFF   = 13'h0000;
    localparam logic [12:0] BG1   = {12'h000, 1'b1};
    localparam logic [12:0] GREEN = {12'h0F0, 1'b1};
    localparam logic [12:0] CYAN  = {12'h0FF, 1'b1};
    localparam logic [12:0] BLUE  = {12'h00F, 1'b1};
    localparam logic [12:0] WHITE = {12'hFFF, 1'b1};

    logic clk;
    logic rst_n;

    vga_bounce_box_if bus0 ();
    vga_bounce_box_if bus1 ();

    vga_bounce_box #(.H_DISPLAY(H), .V_DISPLAY(V), .BOX_SIZE(B), .STEP(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    vga_bounce_box #(.H_DISPLAY(640), .V_DISPLAY(640), .BOX_SIZE(32), .STEP(4)) dut_sq (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [12:0] sb[$];

    // Reference model of the main instance's box state.
    int mbx, mby, mdx, mdy, mc;
    logic mbounce;

    typedef struct {
        logic        de;
        int          x;
        int          y;
        logic [12:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [12:0] got_of(input int sel);
        if (sel == 0)
            return {bus0.vga_r, bus0.vga_g, bus0.vga_b, bus0.de_out};
        return {bus1.vga_r, bus1.vga_g, bus1.vga_b, bus1.de_out};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got rgb=%03h de=%b, expected rgb=%03h de=%b",
                     name, act[12:1], act[0], exp[12:1], exp[0]);
        end
    endtask

    function automatic void model_reset();
        mbx = 0; mby = 0; mdx = 0; mdy = 0; mc = 2;
    endfunction

    function automatic void model_axis(inout int pos, inout int dir, input int lim);
        if (dir == 0) begin
            if (pos + S + B > lim) begin pos = lim - B; dir = 1; mbounce = 1'b1; end
            else pos = pos + S;
        end else begin
            if (pos < S) begin pos = 0; dir = 0; mbounce = 1'b1; end
            else pos = pos - S;
        end
    endfunction

    function automatic void model_tick();
        mbounce = 1'b0;
        model_axis(mbx, mdx, H);
        model_axis(mby, mdy, V);
        if (mbounce) mc = (mc == 7) ? 1 : mc + 1;
    endfunction

    function automatic logic [12:0] model_pix(input logic de, input int x, input int y);
        logic [2:0] c;
        c = 3'(mc);
        if (!de) return OFF;
`ifdef VGA_BORDER_EN
        if (x == 0 || x == H - 1 || y == 0 || y == V - 1) return WHITE;
`endif
        if (x >= mbx && x < mbx + B && y >= mby && y < mby + B)
            return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}, 1'b1};
        return BG1;
    endfunction

    // One pixel strobe (optionally with a same-cycle frame tick); expected
    // value goes through the scoreboard and is compared one strobe later.
    task automatic pixel(input int sel, input logic de, input int x, input int y,
                         input logic tick, input logic [12:0] exp, input string name);
        logic [12:0] e;
        @(negedge clk);
        if (sel == 0) begin
            bus0.pix_en = 1'b1; bus0.de = de; bus0.px = 10'(x); bus0.py = 10'(y);
            bus0.frame_tick = tick;
        end else begin
            bus1.pix_en = 1'b1; bus1.de = de; bus1.px = 10'(x); bus1.py = 10'(y);
            bus1.frame_tick = tick;
        end
        sb.push_back(exp);
        if (tick && sel == 0) model_tick();
        @(negedge clk);
        bus0.pix_en = 1'b0; bus0.frame_tick = 1'b0;
        bus1.pix_en = 1'b0; bus1.frame_tick = 1'b0;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check(name, got_of(sel), e);
        end
    endtask

    task automatic tick(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel == 0) bus0.frame_tick = 1'b1; else bus1.frame_tick = 1'b1;
            if (sel == 0) model_tick();
            @(negedge clk);
            bus0.frame_tick = 1'b0;
            bus1.frame_tick = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.pix_en = 1'b0; bus0.de = 1'b0; bus0.px = '0; bus0.py = '0; bus0.frame_tick = 1'b0;
        bus1.pix_en = 1'b0; bus1.de = 1'b0; bus1.px = '0; bus1.py = '0; bus1.frame_tick = 1'b0;
        model_reset();

        // Reset pixel vectors (box at 0,0, green).
`ifdef VGA_BORDER_EN
        tbl[0] = '{1'b1,   0,   0, WHITE, "origin"};
        tbl[6] = '{1'b1, 639, 479, WHITE, "far_corner"};
`else
        tbl[0] = '{1'b1,   0,   0, GREEN, "origin"};
        tbl[6] = '{1'b1, 639, 479, BG1,   "far_corner"};
`endif
        tbl[1] = '{1'b1,   1,   1, GREEN, "inner_1_1"};
        tbl[2] = '{1'b1,  31,  31, GREEN, "box_last"};
        tbl[3] = '{1'b1,  32,   0, BG1,   "right_of_box"};
        tbl[4] = '{1'b1,   5,  32, BG1,   "below_box"};
        tbl[5] = '{1'b0,   0,   0, OFF,   "de_low"};

        #3;
        check("reset_out0", got_of(0), OFF);
        check("reset_out1", got_of(1), OFF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i])
            pixel(0, tbl[i].de, tbl[i].x, tbl[i].y, 1'b0, tbl[i].exp, tbl[i].name);

        // Outputs hold while the strobe is low.
        pixel(0, 1'b1, 5, 5, 1'b0, GREEN, "pre_hold");
        @(negedge clk);
        bus0.de = 1'b0; bus0.px = 10'd100; bus0.py = 10'd100;
        @(negedge clk);
        @(negedge clk);
        check("hold", got_of(0), GREEN);

        // Same-cycle tick and pixel: pixel sees the old box.
        pixel(0, 1'b1, 1, 1, 1'b1, GREEN, "tick_same_cycle");
        pixel(0, 1'b1,  1,  1, 1'b0, BG1,   "old_spot_after_tick");
        pixel(0, 1'b1,  3,  3, 1'b0, BG1,   "t1_3_3");
        pixel(0, 1'b1,  4,  4, 1'b0, GREEN, "t1_4_4");
        pixel(0, 1'b1, 35, 35, 1'b0, GREEN, "t1_35_35");
        pixel(0, 1'b1, 36, 36, 1'b0, BG1,   "t1_36_36");

        tick(0, 111);
        pixel(0, 1'b1, 448, 448, 1'b0, GREEN, "t112_box");
        pixel(0, 1'b1, 447, 447, 1'b0, BG1,   "t112_outside");
        tick(0, 1);
        pixel(0, 1'b1, 452, 448, 1'b0, CYAN,  "t113_bounce_y");
        pixel(0, 1'b1, 451, 448, 1'b0, BG1,   "t113_outside");
        tick(0, 1);
        pixel(0, 1'b1, 456, 444, 1'b0, CYAN,  "t114_box");
        pixel(0, 1'b1, 455, 444, 1'b0, BG1,   "t114_outside");

        // Run to tick 452 checking the box corner after every bounce.
        for (int t = 115; t <= 452; t++) begin
            tick(0, 1);
            if (mbounce)
                pixel(0, 1'b1, mbx + 1, mby + 1, 1'b0, model_pix(1'b1, mbx + 1, mby + 1),
                      $sformatf("bounce_t%0d", t));
        end
        pixel(0, 1'b1, 600, 10, 1'b0, BLUE, "t452_wrap_blue");
        pixel(0, 1'b1, 583, 10, 1'b0, BG1,  "t452_outside");

        // Asynchronous reset mid-line clears outputs with no clock edge.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset", got_of(0), OFF);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, 1);
        pixel(0, 1'b1, 4, 4, 1'b0, GREEN, "post_reset_4_4");
        pixel(0, 1'b1, 3, 3, 1'b0, BG1,   "post_reset_3_3");

        // Square screen: both axes reach 608 together and bounce on one tick.
        tick(1, 152);
        pixel(1, 1'b1, 608, 608, 1'b0, GREEN, "sq_t152");
        tick(1, 1);
        pixel(1, 1'b1, 608, 608, 1'b0, CYAN,  "sq_double_bounce");
        pixel(1, 1'b1, 607, 607, 1'b0, BG1,   "sq_outside");
        tick(1, 1);
        pixel(1, 1'b1, 604, 604, 1'b0, CYAN,  "sq_t154_box");
        pixel(1, 1'b1, 635, 635, 1'b0, CYAN,  "sq_t154_last");
        pixel(1, 1'b1, 636, 636, 1'b0, BG1,   "sq_t154_outside");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
